// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with configurable width and modulus, wrap or
// saturate behaviour, variable step, synchronous load and count enable.
// Terminal flags are decoded from the registered count; overflow/underflow
// are registered one-cycle pulses marking a crossing on the previous count.
module updown_counter_param #(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = (1 << WIDTH) - 1,
    parameter int SATURATE = 0,
    parameter int RST_VAL  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             control,
    input  logic [WIDTH-1:0] step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             at_max,
    output logic             at_zero,
    output logic             ovf,
    output logic             udf
);

    // Range limits in counter width and in the one-bit-wider arithmetic width
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_W   = WIDTH'(RST_VAL);
    localparam logic [WIDTH:0]   MAX_X   = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   MOD_X   = (WIDTH+1)'(MAX_VAL + 1);

    logic [WIDTH-1:0] out_q, out_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    // Step is clamped to the range top so a single cycle wraps at most once
    logic [WIDTH-1:0] step_clamped;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   down_wrap;
    logic [WIDTH-1:0] up_over_val;
    logic [WIDTH-1:0] down_under_val;
    logic [WIDTH:0]   up_wrap_x;

    // Clamp operands and form the candidate next values for both directions
    always_comb begin
        step_clamped = (step > MAX_W) ? MAX_W : step;
        load_clamped = (load_val > MAX_W) ? MAX_W : load_val;
        up_sum       = {1'b0, out_q} + {1'b0, step_clamped};
        up_wrap_x    = up_sum - MOD_X;
        down_wrap    = {1'b0, out_q} + MOD_X - {1'b0, step_clamped};
    end

    // Boundary behaviour chosen at elaboration: wrap modulo range or clamp
    generate
        if (SATURATE != 0) begin : g_saturate
            assign up_over_val    = MAX_W;
            assign down_under_val = '0;
        end else begin : g_wrap
            assign up_over_val    = up_wrap_x[WIDTH-1:0];
            assign down_under_val = down_wrap[WIDTH-1:0];
        end
    endgenerate

    // Next-state selection: load beats count, count beats hold
    always_comb begin
        out_d = out_q;
        ovf_d = 1'b0;
        udf_d = 1'b0;
        if (load) begin
            out_d = load_clamped;
        end else if (en) begin
            if (control) begin
                if (up_sum > MAX_X) begin
                    ovf_d = 1'b1;
                    out_d = up_over_val;
                end else begin
                    out_d = up_sum[WIDTH-1:0];
                end
            end else begin
                if (out_q >= step_clamped) begin
                    out_d = out_q - step_clamped;
                end else begin
                    udf_d = 1'b1;
                    out_d = down_under_val;
                end
            end
        end
    end

    // State register with synchronous active-low reset overriding everything
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_q <= RST_W;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            out_q <= out_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign out     = out_q;
    assign ovf     = ovf_q;
    assign udf     = udf_q;
    assign at_max  = (out_q == MAX_W);
    assign at_zero = (out_q == '0);

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench for updown_counter_param. Three instances share one stimulus
// stream: 4-bit full-range wrap, modulus-10 wrap and modulus-10 saturate.
module tb_updown_counter_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       control;
    logic [3:0] step_v;
    logic       load;
    logic [3:0] load_val;

    logic [3:0] a_out, b_out, c_out;
    logic       a_max, a_zero, a_ovf, a_udf;
    logic       b_max, b_zero, b_ovf, b_udf;
    logic       c_max, c_zero, c_ovf, c_udf;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Full 4-bit range, wrap
    updown_counter_param #(.WIDTH(4)) u_a (
        .clk(clk), .rst(rst_n), .en(en), .control(control), .step(step_v),
        .load(load), .load_val(load_val), .out(a_out), .at_max(a_max),
        .at_zero(a_zero), .ovf(a_ovf), .udf(a_udf)
    );

    // Modulus 10, wrap
    updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0)) u_b (
        .clk(clk), .rst(rst_n), .en(en), .control(control), .step(step_v),
        .load(load), .load_val(load_val), .out(b_out), .at_max(b_max),
        .at_zero(b_zero), .ovf(b_ovf), .udf(b_udf)
    );

    // Modulus 10, saturate
    updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1)) u_c (
        .clk(clk), .rst(rst_n), .en(en), .control(control), .step(step_v),
        .load(load), .load_val(load_val), .out(c_out), .at_max(c_max),
        .at_zero(c_zero), .ovf(c_ovf), .udf(c_udf)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s = %0d", tag, obs);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge
    task automatic cyc(input logic r, input logic ld, input logic [3:0] lv,
                       input logic e, input logic c, input logic [3:0] s);
        rst_n    = r;
        load     = ld;
        load_val = lv;
        en       = e;
        control  = c;
        step_v   = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; control = 1'b0; step_v = '0;

        // Reset for two cycles, then release with en low
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 7, 1, 1, 3);
        check_eq("rst a_out",  a_out, 0);
        check_eq("rst a_zero", a_zero, 1);
        check_eq("rst a_max",  a_max, 0);
        check_eq("rst a_ovf",  a_ovf, 0);
        check_eq("rst a_udf",  a_udf, 0);
        check_eq("rst b_out",  b_out, 0);
        check_eq("rst c_out",  c_out, 0);
        cyc(1, 0, 0, 0, 1, 5);
        check_eq("hold a_out", a_out, 0);
        check_eq("hold b_out", b_out, 0);

        // Full-range wrap: load 14, count up by 1
        cyc(1, 1, 14, 0, 0, 0);
        check_eq("ld14 a_out", a_out, 14);
        check_eq("ld14 b_out clamp", b_out, 9);
        check_eq("ld14 b_max", b_max, 1);
        cyc(1, 0, 0, 1, 1, 1);
        check_eq("up1 a_out", a_out, 15);
        check_eq("up1 a_max", a_max, 1);
        check_eq("up1 a_ovf", a_ovf, 0);
        cyc(1, 0, 0, 1, 1, 1);
        check_eq("up2 a_out", a_out, 0);
        check_eq("up2 a_ovf", a_ovf, 1);
        check_eq("up2 a_zero", a_zero, 1);
        cyc(1, 0, 0, 1, 1, 1);
        check_eq("up3 a_out", a_out, 1);
        check_eq("up3 a_ovf", a_ovf, 0);

        // Modulus-10 wrap down: 2 - 5 -> 7 with udf, then 7 - 7 -> 0
        cyc(1, 1, 2, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 5);
        check_eq("dn5 b_out", b_out, 7);
        check_eq("dn5 b_udf", b_udf, 1);
        check_eq("dn5 b_ovf", b_ovf, 0);
        check_eq("dn5 a_out", a_out, 13);
        check_eq("dn5 a_udf", a_udf, 1);
        cyc(1, 0, 0, 1, 0, 7);
        check_eq("dn7 b_out", b_out, 0);
        check_eq("dn7 b_udf", b_udf, 0);
        check_eq("dn7 b_zero", b_zero, 1);
        check_eq("dn7 a_out", a_out, 6);
        // Oversized step clamps to 9: 0 - 9 wraps to 1
        cyc(1, 0, 0, 1, 0, 12);
        check_eq("dn12 b_out", b_out, 1);
        check_eq("dn12 b_udf", b_udf, 1);
        cyc(1, 0, 0, 0, 0, 3);
        check_eq("idle b_out", b_out, 1);
        check_eq("idle b_udf", b_udf, 0);

        // Saturate up at 9; wrap instance crosses once
        cyc(1, 1, 8, 0, 0, 0);
        cyc(1, 0, 0, 1, 1, 3);
        check_eq("sup1 c_out", c_out, 9);
        check_eq("sup1 c_ovf", c_ovf, 1);
        check_eq("sup1 c_max", c_max, 1);
        check_eq("sup1 b_out", b_out, 1);
        check_eq("sup1 b_ovf", b_ovf, 1);
        cyc(1, 0, 0, 1, 1, 3);
        check_eq("sup2 c_out", c_out, 9);
        check_eq("sup2 c_ovf", c_ovf, 1);
        check_eq("sup2 b_out", b_out, 4);
        check_eq("sup2 b_ovf", b_ovf, 0);
        cyc(1, 0, 0, 1, 1, 0);
        check_eq("step0 c_out", c_out, 9);
        check_eq("step0 c_ovf", c_ovf, 0);

        // Saturate down at 0
        cyc(1, 1, 1, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 4);
        check_eq("sdn1 c_out", c_out, 0);
        check_eq("sdn1 c_udf", c_udf, 1);
        check_eq("sdn1 b_out", b_out, 7);
        cyc(1, 0, 0, 1, 0, 4);
        check_eq("sdn2 c_out", c_out, 0);
        check_eq("sdn2 c_udf", c_udf, 1);
        check_eq("sdn2 c_ovf", c_ovf, 0);

        // Full-range wrap with maximum step: 15 + 15 -> 14
        cyc(1, 1, 15, 0, 0, 0);
        cyc(1, 0, 0, 1, 1, 15);
        check_eq("up15 a_out", a_out, 14);
        check_eq("up15 a_ovf", a_ovf, 1);

        // Load beats count; reset beats load
        cyc(1, 1, 12, 1, 1, 3);
        check_eq("pri b_out", b_out, 9);
        check_eq("pri b_ovf", b_ovf, 0);
        check_eq("pri a_out", a_out, 12);
        check_eq("pri a_ovf", a_ovf, 0);
        cyc(0, 1, 12, 1, 1, 3);
        check_eq("prirst a_out", a_out, 0);
        check_eq("prirst b_out", b_out, 0);
        check_eq("prirst c_out", c_out, 0);
        check_eq("prirst c_zero", c_zero, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
